// File: rtl/dequant_pkg.sv
// Shared widths, shift limit and configuration record for the dequantiser.
// The shift limit keeps every result inside the default 64-bit output.
package dequant_pkg;

    localparam int Q_W_DEF = 8;
    localparam int D_W_DEF = 64;
    localparam int M_W_DEF = 32;
    localparam int SHIFT_W = 5;

    localparam logic [SHIFT_W-1:0] SHIFT_MAX = 5'd23;

    typedef struct packed {
        logic [M_W_DEF-1:0] scale;
        logic [SHIFT_W-1:0] shift;
        logic [Q_W_DEF-1:0] zp;
    } cfg_t;

    localparam cfg_t CFG_RST = '{scale: M_W_DEF'(1), shift: 5'd0, zp: 8'd0};

    function automatic logic [SHIFT_W-1:0] clamp_shift(input logic [SHIFT_W-1:0] s);
        return (s > SHIFT_MAX) ? SHIFT_MAX : s;
    endfunction

endpackage

// File: rtl/dequant_cfg_regs.sv
// Scale/shift/zero-point registers; loads only when the pipeline is empty and no input is offered.
// Rejected writes set a sticky cfg_err that only reset clears.
module dequant_cfg_regs
    import dequant_pkg::*;
#(
    parameter int Q_W = Q_W_DEF,
    parameter int M_W = M_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [M_W-1:0]     cfg_scale,
    input  logic [SHIFT_W-1:0] cfg_shift,
    input  logic [Q_W-1:0]     cfg_zp,
    input  logic               busy,
    input  logic               in_valid,
    output logic [M_W-1:0]     scale,
    output logic [SHIFT_W-1:0] shift,
    output logic [Q_W-1:0]     zp,
    output logic               cfg_err
);

    logic               cfg_ok;
    logic [M_W-1:0]     scale_q, scale_d;
    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic [Q_W-1:0]     zp_q, zp_d;
    logic               cfg_err_q, cfg_err_d;

    always_comb begin
        cfg_ok    = cfg_we & ~busy & ~in_valid;
        scale_d   = scale_q;
        shift_d   = shift_q;
        zp_d      = zp_q;
        cfg_err_d = cfg_err_q | (cfg_we & ~cfg_ok);
        if (cfg_ok) begin
            scale_d = cfg_scale;
            shift_d = clamp_shift(cfg_shift);
            zp_d    = cfg_zp;
        end
    end

    // Deliberately independent of en: configuration stays writable while the datapath is frozen.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scale_q   <= M_W'(CFG_RST.scale);
            shift_q   <= CFG_RST.shift;
            zp_q      <= Q_W'(CFG_RST.zp);
            cfg_err_q <= 1'b0;
        end else begin
            scale_q   <= scale_d;
            shift_q   <= shift_d;
            zp_q      <= zp_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign scale   = scale_q;
    assign shift   = shift_q;
    assign zp      = zp_q;
    assign cfg_err = cfg_err_q;

endmodule

// File: rtl/dequant_unit.sv
// d_out = ((q_in - zp) * scale) <<< shift; 2-cycle latency, 1 sample/cycle; whole pipe stalls on en=0 or out_ready=0.
// DEQUANT_RELU_EN: when defined, negative results are replaced by 0 before the output register.
module dequant_unit
    import dequant_pkg::*;
#(
    parameter int Q_W = Q_W_DEF,
    parameter int D_W = D_W_DEF,
    parameter int M_W = M_W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           cfg_we,
    input  logic [M_W-1:0] cfg_scale,
    input  logic [4:0]     cfg_shift,
    input  logic [Q_W-1:0] cfg_zp,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [Q_W-1:0] q_in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [D_W-1:0] d_out,
    output logic           busy,
    output logic           cfg_err,
    output logic [31:0]    sample_cnt
);

    localparam int DIFF_W = Q_W + 1;
    localparam int PROD_W = Q_W + 1 + M_W;

    logic [M_W-1:0]     scale;
    logic [SHIFT_W-1:0] shift;
    logic [Q_W-1:0]     zp;

    logic              adv, out_xfer;
    logic              s1_vld_q, s1_vld_d;
    logic [DIFF_W-1:0] s1_dat_q, s1_dat_d;
    logic              s2_vld_q, s2_vld_d;
    logic [D_W-1:0]    s2_dat_q, s2_dat_d;
    logic [31:0]       cnt_q, cnt_d;

    logic [DIFF_W-1:0] diff;
    logic [PROD_W-1:0] op_a, op_b, prod;
    logic [D_W-1:0]    prod_ext, shifted, res;

    dequant_cfg_regs #(
        .Q_W (Q_W),
        .M_W (M_W)
    ) u_cfg (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_scale (cfg_scale),
        .cfg_shift (cfg_shift),
        .cfg_zp    (cfg_zp),
        .busy      (busy),
        .in_valid  (in_valid),
        .scale     (scale),
        .shift     (shift),
        .zp        (zp),
        .cfg_err   (cfg_err)
    );

    always_comb begin
        adv      = en & (~s2_vld_q | out_ready);
        out_xfer = en & s2_vld_q & out_ready;

        diff = {q_in[Q_W-1], q_in} - {zp[Q_W-1], zp};

        // Operands widened to the full product width so the truncated product is the exact signed result.
        op_a     = {{M_W{s1_dat_q[DIFF_W-1]}}, s1_dat_q};
        op_b     = {{DIFF_W{1'b0}}, scale};
        prod     = op_a * op_b;
        prod_ext = {{(D_W-PROD_W){prod[PROD_W-1]}}, prod};
        shifted  = prod_ext << shift;
`ifdef DEQUANT_RELU_EN
        res = shifted[D_W-1] ? '0 : shifted;
`else
        res = shifted;
`endif

        s1_vld_d = s1_vld_q;
        s1_dat_d = s1_dat_q;
        s2_vld_d = s2_vld_q;
        s2_dat_d = s2_dat_q;
        if (adv) begin
            s1_vld_d = in_valid;
            s2_vld_d = s1_vld_q;
            if (in_valid) s1_dat_d = diff;
            if (s1_vld_q) s2_dat_d = res;
        end

        cnt_d = cnt_q + {31'd0, out_xfer};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_vld_q <= 1'b0;
            s1_dat_q <= '0;
            s2_vld_q <= 1'b0;
            s2_dat_q <= '0;
            cnt_q    <= '0;
        end else begin
            s1_vld_q <= s1_vld_d;
            s1_dat_q <= s1_dat_d;
            s2_vld_q <= s2_vld_d;
            s2_dat_q <= s2_dat_d;
            cnt_q    <= cnt_d;
        end
    end

    assign in_ready   = adv;
    assign out_valid  = s2_vld_q;
    assign d_out      = s2_dat_q;
    assign busy       = s1_vld_q | s2_vld_q;
    assign sample_cnt = cnt_q;

endmodule
